// File: rtl/mem_port_arbiter_pkg.sv
// Shared cpu6 definitions for the memory-port arbiter: data width and FSM state encodings.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

package mem_port_arbiter_pkg;

  localparam int unsigned CPU6_XLEN = `CPU6_XLEN;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_e;

  // Width of the consecutive-D-grant counter; never narrower than one bit.
  function automatic int unsigned streak_w(input int unsigned max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// IDLE winner selection: data first, unless fetch has been waiting through MAX_D_STREAK data grants.
module arb_prio_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 2,
  parameter int unsigned SW           = streak_w(MAX_D_STREAK)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] d_streak,
  output logic          grant_if,
  output logic          grant_d,
  output logic [SW-1:0] next_streak
);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  always_comb begin
    grant_d     = d_req && !(if_req && (d_streak == STREAK_MAX));
    grant_if    = if_req && !grant_d;
    next_streak = d_streak;
    if (grant_d) begin
      // Only D grants that make a pending fetch wait extend the streak.
      if (if_req) begin
        next_streak = (d_streak == STREAK_MAX) ? d_streak : d_streak + 1'b1;
      end else begin
        next_streak = '0;
      end
    end else if (grant_if) begin
      next_streak = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single cpu6 memory port between instruction fetch and load/store, one access at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = CPU6_XLEN,
  parameter int unsigned MAX_D_STREAK = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned SW = streak_w(MAX_D_STREAK);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic            grant_if, grant_d;
  logic [SW-1:0]   pick_streak;

  arb_prio_pick #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .SW          (SW)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .d_streak   (streak_q),
    .grant_if   (grant_if),
    .grant_d    (grant_d),
    .next_streak(pick_streak)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d     = ARB_BUSY_D;
          streak_d    = pick_streak;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_if) begin
          state_d     = ARB_BUSY_IF;
          streak_d    = pick_streak;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_D: begin
        if (mem_ack) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Acks are combinational from mem_ack so the owner completes in the memory's ack cycle.
  always_comb begin
    if_ack   = !reset && (state_q == ARB_BUSY_IF) && mem_ack;
    d_ack    = !reset && (state_q == ARB_BUSY_D) && mem_ack;
    if_rdata = (state_q == ARB_BUSY_IF) ? mem_rdata : '0;
    d_rdata  = (state_q == ARB_BUSY_D) ? mem_rdata : '0;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle table, directed corner sequences, randomized traffic vs grant-history model.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int MAXS = 2;
  localparam int CW   = 160;
  localparam int NTBL = 18;
  localparam logic [XLEN-1:0] IF_A = 32'h100;
  localparam logic [XLEN-1:0] D_A  = 32'h200;
  localparam logic [XLEN-1:0] D_WD = 32'h55;
  localparam logic [XLEN-1:0] RD   = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req, if_ack, d_req, d_we, d_ack;
  logic [XLEN-1:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic            mem_req, mem_we, mem_ack;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .XLEN        (XLEN),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic       ifr;
    logic       dr;
    logic       mack;
    logic       mreq;
    logic [1:0] bus;    // 0: bus not checked, 1: fetch on bus, 2: data store on bus
    logic       ifack;
    logic       dack;
  } vec_t;

  typedef struct {
    bit is_d;
    bit if_pend;
  } grant_t;

  vec_t   tbl [NTBL];
  grant_t hist[$];

  int vectors     = 0;
  int miscompares = 0;
  bit if_hold     = 1'b0;
  bit d_hold      = 1'b0;

  bit              ifp, dp, busy, ack_prev, owner_d, prev_if, prev_d, exp_ifack, exp_dack;
  int              lat;
  logic [2*XLEN:0] exp_bus;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // A requester must keep req high from issue until its ack.
  task automatic sample();
    @(negedge clk);
    if (!reset) begin
      assert (!(if_hold && !if_req) && !(d_hold && !d_req))
      else begin
        miscompares++;
        $display("FAIL protocol: req dropped before ack (if_req=%0b d_req=%0b)", if_req, d_req);
      end
    end
    if_hold = !reset && if_req && !if_ack;
    d_hold  = !reset && d_req && !d_ack;
  endtask

  // Data wins unless fetch waits and the trailing run of fetch-blocking data grants is already MAXS long.
  function automatic bit d_should_win(input bit ifq, input bit dq);
    int run = 0;
    if (!dq) return 1'b0;
    if (!ifq) return 1'b1;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].is_d && hist[i].if_pend) run++;
      else break;
    end
    return run < MAXS;
  endfunction

  initial begin
    //           ifr   dr    mack  mreq  bus   ifack dack
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = IF_A;
    d_req     = 1'b0;
    d_we      = 1'b1;
    d_addr    = D_A;
    d_wdata   = D_WD;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sample();
    chk("reset_state", CW'({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack}), '0);

    // Arbitration table: simultaneous requests, D,D,IF,D,D,IF order, 0-latency and spurious acks.
    for (int i = 0; i < NTBL; i++) begin
      next_cycle();
      if_req    = tbl[i].ifr;
      d_req     = tbl[i].dr;
      mem_ack   = tbl[i].mack;
      mem_rdata = tbl[i].mack ? RD : '0;
      sample();
      chk($sformatf("tbl[%0d] ctrl", i), CW'({if_ack, d_ack, mem_req}),
          CW'({tbl[i].ifack, tbl[i].dack, tbl[i].mreq}));
      if (tbl[i].bus != 2'd0) begin
        exp_bus = (tbl[i].bus == 2'd1) ? {1'b0, IF_A, {XLEN{1'b0}}} : {1'b1, D_A, D_WD};
        chk($sformatf("tbl[%0d] bus", i), CW'({mem_we, mem_addr, mem_wdata}), CW'(exp_bus));
      end
      chk($sformatf("tbl[%0d] rdata", i), CW'({if_rdata, d_rdata}),
          CW'({tbl[i].ifack ? RD : 32'h0, tbl[i].dack ? RD : 32'h0}));
    end

    // Single fetch, memory acks on the third cycle after mem_req rises.
    next_cycle();
    if_req  = 1'b1;
    if_addr = IF_A;
    mem_ack = 1'b0;
    mem_rdata = '0;
    sample();
    chk("fetch_idle", CW'(mem_req), CW'(1'b0));
    next_cycle();
    sample();
    chk("fetch_grant", CW'({mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack}),
        CW'({1'b1, 1'b0, IF_A, 32'h0, 1'b0, 1'b0}));
    repeat (2) begin
      next_cycle();
      sample();
      chk("fetch_wait", CW'({mem_req, if_ack, d_ack}), CW'({1'b1, 1'b0, 1'b0}));
    end
    next_cycle();
    mem_ack   = 1'b1;
    mem_rdata = RD;
    sample();
    chk("fetch_ack", CW'({if_ack, d_ack, if_rdata, d_rdata}), CW'({1'b1, 1'b0, RD, 32'h0}));
    next_cycle();
    if_req    = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    sample();
    chk("fetch_release", CW'({mem_req, if_ack, d_ack}), '0);

    // Reset while a data load is in flight; a late memory ack must be ignored.
    next_cycle();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h300;
    sample();
    next_cycle();
    sample();
    chk("rst_grant", CW'({mem_req, mem_we, mem_addr}), CW'({1'b1, 1'b0, 32'h300}));
    next_cycle();
    reset = 1'b1;
    d_req = 1'b0;
    sample();
    next_cycle();
    reset = 1'b0;
    sample();
    chk("rst_clear", CW'({mem_req, mem_we, mem_addr, mem_wdata}), '0);
    next_cycle();
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234;
    sample();
    chk("rst_late_ack", CW'({if_ack, d_ack, if_rdata, d_rdata}), '0);
    next_cycle();
    mem_ack = 1'b0;
    sample();
    chk("rst_idle", CW'(mem_req), CW'(1'b0));

    // Randomized traffic with variable latency and spurious idle acks.
    hist.delete();
    ifp = 1'b0; dp = 1'b0; busy = 1'b0; ack_prev = 1'b0; owner_d = 1'b0; lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      prev_if = if_req;
      prev_d  = d_req;
      if (ack_prev) begin
        busy = 1'b0;
        chk("rnd_gap", CW'(mem_req), CW'(1'b0));
      end else if (busy) begin
        chk("rnd_hold", CW'({mem_req, mem_we, mem_addr, mem_wdata}), CW'({1'b1, exp_bus}));
      end else if (prev_if || prev_d) begin
        owner_d = d_should_win(prev_if, prev_d);
        hist.push_back('{owner_d, prev_if});
        exp_bus = owner_d ? {d_we, d_addr, d_wdata} : {1'b0, if_addr, {XLEN{1'b0}}};
        busy    = 1'b1;
        lat     = int'($urandom_range(0, 3));
        chk("rnd_grant", CW'({mem_req, mem_we, mem_addr, mem_wdata}), CW'({1'b1, exp_bus}));
      end else begin
        chk("rnd_idle", CW'(mem_req), CW'(1'b0));
      end
      ack_prev = 1'b0;

      if (busy && lat == 0) mem_ack = 1'b1;
      else mem_ack = !busy && ($urandom_range(0, 7) == 0);
      if (busy && lat > 0) lat--;
      mem_rdata = $urandom();

      if (!ifp && $urandom_range(0, 2) == 0) begin
        ifp     = 1'b1;
        if_addr = $urandom();
      end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp      = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom();
        d_wdata = $urandom();
      end
      if_req = ifp;
      d_req  = dp;

      sample();
      exp_ifack = busy && !owner_d && mem_ack;
      exp_dack  = busy && owner_d && mem_ack;
      chk("rnd_ack", CW'({if_ack, d_ack, if_rdata, d_rdata}),
          CW'({exp_ifack, exp_dack, (busy && !owner_d) ? mem_rdata : 32'h0,
               (busy && owner_d) ? mem_rdata : 32'h0}));
      if (exp_ifack) ifp = 1'b0;
      if (exp_dack) dp = 1'b0;
      ack_prev = exp_ifack || exp_dack;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
